// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - MEM pipeline stage: split-bus load wait, response buffer, stale-response cancel, ID forwarding
module mem_stage_hs #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int PC_W     = 32,
  parameter int CANCEL_W = 2,
  localparam int ES_WD   = 6 + REG_AW + DATA_W + PC_W,
  localparam int MS_WD   = 1 + REG_AW + DATA_W + PC_W,
  localparam int FWD_WD  = 3 + REG_AW + DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              es_cancel_req,
  input  logic              ws_allowin,
  output logic              ms_allowin,
  input  logic              es_to_ms_valid,
  input  logic [ES_WD-1:0]  es_to_ms_bus,
  output logic              ms_to_ws_valid,
  output logic [MS_WD-1:0]  ms_to_ws_bus,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic [FWD_WD-1:0] ms_fwd_bus
);

  logic                ms_valid;
  logic [ES_WD-1:0]    es_bus_r;
  logic                buf_valid;
  logic [DATA_W-1:0]   buf_data;
  logic [CANCEL_W-1:0] cancel_cnt;

  logic [2:0]          ld_op;
  logic                req_issued;
  logic                res_from_mem;
  logic                gr_we;
  logic [REG_AW-1:0]   dest;
  logic [DATA_W-1:0]   alu_result;
  logic [PC_W-1:0]     pc;

  assign {ld_op, req_issued, res_from_mem, gr_we, dest, alu_result, pc} = es_bus_r;

  logic need_data;
  logic resp_hit;
  logic ms_ready_go;
  logic handoff;
  logic buf_capture;
  logic dead_inflight;
  logic cancel_drop;
  logic [CANCEL_W:0] cancel_next;

  assign need_data      = ms_valid && req_issued && res_from_mem;
  assign resp_hit       = data_sram_data_ok && (cancel_cnt == '0);
  assign ms_ready_go    = !need_data || buf_valid || resp_hit;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign handoff        = ms_to_ws_valid && ws_allowin;
  assign buf_capture    = resp_hit && need_data && !buf_valid && !ws_allowin;
  // A flushed load whose response has not yet arrived still owes us one data_ok.
  assign dead_inflight  = flush && need_data && !buf_valid && !resp_hit;
  assign cancel_drop    = data_sram_data_ok && (cancel_cnt != '0);

  assign cancel_next = {1'b0, cancel_cnt}
                     + {{CANCEL_W{1'b0}}, es_cancel_req}
                     + {{CANCEL_W{1'b0}}, dead_inflight}
                     - {{CANCEL_W{1'b0}}, cancel_drop};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid   <= 1'b0;
      es_bus_r   <= '0;
      buf_valid  <= 1'b0;
      buf_data   <= '0;
      cancel_cnt <= '0;
    end else begin
      if (flush) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end

      if (es_to_ms_valid && ms_allowin && !flush) begin
        es_bus_r <= es_to_ms_bus;
      end

      if (flush || handoff) begin
        buf_valid <= 1'b0;
      end else if (buf_capture) begin
        buf_valid <= 1'b1;
        buf_data  <= data_sram_rdata;
      end

      cancel_cnt <= cancel_next[CANCEL_W-1:0];
    end
  end

  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] ld_result;
  logic [DATA_W-1:0] final_result;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  always_comb begin
    raw = buf_valid ? buf_data : data_sram_rdata;
    case (alu_result[1:0])
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = alu_result[1] ? raw[31:16] : raw[15:0];
    case (ld_op)
      3'b001:  ld_result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      3'b010:  ld_result = {{(DATA_W-8){1'b0}}, byte_sel};
      3'b011:  ld_result = {{(DATA_W-16){half_sel[15]}}, half_sel};
      3'b100:  ld_result = {{(DATA_W-16){1'b0}}, half_sel};
      default: ld_result = raw;
    endcase
    final_result = res_from_mem ? ld_result : alu_result;
  end

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

  // MSB flags MS occupancy; the whole bus reads zero when MS is empty so ID never matches stale dest.
  assign ms_fwd_bus = ms_valid ? {1'b1, gr_we, ms_ready_go, dest, final_result} : '0;

  cancel_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !cancel_next[CANCEL_W]);

  no_stray_response: assert property (@(posedge clk) disable iff (!resetn)
    !(data_sram_data_ok && (cancel_cnt == '0) && !(need_data && !buf_valid)));

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - self-checking bench for mem_stage_hs with directed scenarios and a randomized scoreboard run
module tb_mem_stage_hs;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        es_cancel_req;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [39:0] ms_fwd_bus;

  int checks = 0;
  int errors = 0;

  mem_stage_hs dut (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (flush),
    .es_cancel_req     (es_cancel_req),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_fwd_bus        (ms_fwd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [74:0] mk(input logic [2:0] op, input logic req, input logic rfm,
                                     input logic we, input logic [4:0] d,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {op, req, rfm, we, d, alu, pc};
  endfunction

  // Load result from the ISA definition: pick the lane by shifting, sign-extend by subtraction.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * a)) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; flush = 1'b0; es_cancel_req = 1'b0; ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ms_to_ws_valid); end
    checks++;
    if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin); end
    checks++;
    if (ms_fwd_bus !== 40'h0) begin errors++; $display("FAIL reset_fwd: got %h expected 0", ms_fwd_bus); end
    checks++;
    if (ms_to_ws_bus !== 70'h0) begin errors++; $display("FAIL reset_bus: got %h expected 0", ms_to_ws_bus); end
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_alu;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h100);
    #1;
    checks++;
    if (ms_allowin !== 1'b1) begin errors++; $display("FAIL alu_allowin: got %b expected 1", ms_allowin); end
    tick;
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b expected 1", ms_to_ws_valid); end
    checks++;
    if (ms_to_ws_bus !== {1'b1, 5'd5, 32'h1234, 32'h100})
      begin errors++; $display("FAIL alu_bus: got %h expected %h", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234, 32'h100}); end
    checks++;
    if (ms_fwd_bus !== {3'b111, 5'd5, 32'h1234})
      begin errors++; $display("FAIL alu_fwd: got %h expected %h", ms_fwd_bus, {3'b111, 5'd5, 32'h1234}); end
    tick;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL alu_drain: got %b expected 0", ms_to_ws_valid); end
    tick;
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd,
                         input int delay, input logic [4:0] d, input logic [31:0] exp_res,
                         input string name);
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(op, 1'b1, 1'b1, 1'b1, d, addr, 32'h200);
    tick;
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checks++;
      if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0 || ms_fwd_bus[37] !== 1'b0)
        begin errors++; $display("FAIL %s_stall: got valid=%b allowin=%b res_valid=%b expected 0,0,0",
                                 name, ms_to_ws_valid, ms_allowin, ms_fwd_bus[37]); end
      tick;
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = rd;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== exp_res)
      begin errors++; $display("FAIL %s_result: got valid=%b data=%h expected 1, %h",
                               name, ms_to_ws_valid, ms_to_ws_bus[63:32], exp_res); end
    tick;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
  endtask

  task automatic test_load_stall;
    do_load(3'b001, 32'h1003, 32'h80FF_0011, 2, 5'd7, 32'hFFFF_FF80, "lb");
    do_load(3'b010, 32'h1003, 32'h80FF_0011, 0, 5'd8, 32'h0000_0080, "lbu");
  endtask

  task automatic test_backpressure;
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b011, 1'b1, 1'b1, 1'b1, 5'd6, 32'h2002, 32'h300);
    tick;
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80FF_0011;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0)
      begin errors++; $display("FAIL bp_hit: got valid=%b allowin=%b expected 1,0", ms_to_ws_valid, ms_allowin); end
    tick;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h1111_2222;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0 || ms_to_ws_bus[63:32] !== 32'hFFFF_80FF)
        begin errors++; $display("FAIL bp_hold: got valid=%b allowin=%b data=%h expected 1,0,ffff80ff",
                                 ms_to_ws_valid, ms_allowin, ms_to_ws_bus[63:32]); end
      tick;
    end
    checks++;
    if (dut.buf_valid !== 1'b1 || dut.buf_data[31:16] !== 16'h80FF)
      begin errors++; $display("FAIL bp_buf: got buf_valid=%b half=%h expected 1,80ff", dut.buf_valid, dut.buf_data[31:16]); end
    ws_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hFFFF_80FF)
      begin errors++; $display("FAIL bp_release: got valid=%b allowin=%b data=%h expected 1,1,ffff80ff",
                               ms_to_ws_valid, ms_allowin, ms_to_ws_bus[63:32]); end
    tick;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", ms_to_ws_valid); end
    tick;
  endtask

  task automatic test_flush_drop;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b1, 1'b1, 1'b1, 5'd9, 32'h3000, 32'h400);
    tick;
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fd_flush_valid: got %b expected 0", ms_to_ws_valid); end
    tick;
    flush = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0000_DEAD;
    @(negedge clk);
    checks++;
    if (dut.cancel_cnt !== 2'd1 || ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1)
      begin errors++; $display("FAIL fd_stale: got cnt=%0d valid=%b allowin=%b expected 1,0,1",
                               dut.cancel_cnt, ms_to_ws_valid, ms_allowin); end
    tick;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.cancel_cnt !== 2'd0) begin errors++; $display("FAIL fd_cnt_zero: got %0d expected 0", dut.cancel_cnt); end
    tick;
    do_load(3'b000, 32'h3004, 32'h0000_0042, 1, 5'd10, 32'h0000_0042, "fd_next");
  endtask

  task automatic test_double_cancel;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b1, 1'b1, 1'b1, 5'd11, 32'h4000, 32'h500);
    tick;
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    es_cancel_req = 1'b1;
    tick;
    flush = 1'b0;
    es_cancel_req = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b1, 1'b1, 1'b1, 5'd12, 32'h4004, 32'h504);
    @(negedge clk);
    checks++;
    if (dut.cancel_cnt !== 2'd2 || ms_allowin !== 1'b1)
      begin errors++; $display("FAIL dc_cnt_two: got cnt=%0d allowin=%b expected 2,1", dut.cancel_cnt, ms_allowin); end
    tick;
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0000_BAD1;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL dc_drop1: got %b expected 0", ms_to_ws_valid); end
    tick;
    data_sram_rdata = 32'h0000_BAD2;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b0 || dut.cancel_cnt !== 2'd1)
      begin errors++; $display("FAIL dc_drop2: got valid=%b cnt=%0d expected 0,1", ms_to_ws_valid, dut.cancel_cnt); end
    tick;
    data_sram_rdata = 32'h0000_0055;
    @(negedge clk);
    checks++;
    if (dut.cancel_cnt !== 2'd0 || ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_0055)
      begin errors++; $display("FAIL dc_deliver: got cnt=%0d valid=%b data=%h expected 0,1,00000055",
                               dut.cancel_cnt, ms_to_ws_valid, ms_to_ws_bus[63:32]); end
    tick;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_hit;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b000, 1'b1, 1'b1, 1'b1, 5'd13, 32'h5000, 32'h600);
    tick;
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0000_0077;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fh_valid: got %b expected 0", ms_to_ws_valid); end
    tick;
    data_sram_data_ok = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.cancel_cnt !== 2'd0 || ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_fwd_bus !== 40'h0)
      begin errors++; $display("FAIL fh_after: got cnt=%0d allowin=%b valid=%b fwd=%h expected 0,1,0,0",
                               dut.cancel_cnt, ms_allowin, ms_to_ws_valid, ms_fwd_bus); end
    tick;
  endtask

  task automatic test_random;
    logic [69:0] exp_q[$];
    logic [69:0] exp_bus;
    logic [74:0] cur_bus;
    logic [69:0] cur_exp;
    logic [31:0] cur_rdata;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] resp_data;
    logic [2:0]  op;
    logic [4:0]  d;
    logic        we;
    logic        is_load;
    logic        cur_is_load;
    logic        offering;
    logic        resp_pending;
    int          resp_cnt;
    int          issued;
    int          delivered;
    localparam int N = 300;
    offering = 1'b0; resp_pending = 1'b0; resp_cnt = 0; issued = 0; delivered = 0;
    cur_bus = '0; cur_exp = '0; cur_rdata = '0; cur_is_load = 1'b0; resp_data = '0;
    for (int cyc = 0; cyc < 6000 && delivered < N; cyc++) begin
      ws_allowin = ($urandom_range(0, 3) != 0);
      if (resp_pending && resp_cnt == 0) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata = resp_data;
        resp_pending = 1'b0;
      end else begin
        if (resp_pending) resp_cnt--;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = $urandom;
      end
      if (!offering && issued < N && $urandom_range(0, 2) != 0) begin
        is_load = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 7));
        alu = $urandom;
        pc = $urandom;
        d = 5'($urandom);
        we = 1'($urandom);
        cur_rdata = $urandom;
        res = is_load ? ref_load(op, alu[1:0], cur_rdata) : alu;
        cur_bus = mk(op, is_load, is_load, we, d, alu, pc);
        cur_exp = {we, d, res, pc};
        cur_is_load = is_load;
        offering = 1'b1;
      end
      es_to_ms_valid = offering;
      es_to_ms_bus = cur_bus;
      @(negedge clk);
      if (ms_to_ws_valid && ws_allowin) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got bus %h expected no output", ms_to_ws_bus);
        end else begin
          exp_bus = exp_q.pop_front();
          delivered++;
          if (ms_to_ws_bus !== exp_bus)
            begin errors++; $display("FAIL rand_bus: got %h expected %h", ms_to_ws_bus, exp_bus); end
        end
      end
      if (es_to_ms_valid && ms_allowin) begin
        exp_q.push_back(cur_exp);
        issued++;
        offering = 1'b0;
        if (cur_is_load) begin
          resp_pending = 1'b1;
          resp_cnt = $urandom_range(0, 3);
          resp_data = cur_rdata;
        end
      end
      tick;
    end
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    ws_allowin = 1'b1;
    checks++;
    if (delivered != N) begin errors++; $display("FAIL rand_count: got %0d delivered expected %0d", delivered, N); end
    tick;
  endtask

  task automatic test_reset_mid;
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'b011, 1'b1, 1'b1, 1'b1, 5'd14, 32'h6002, 32'h700);
    tick;
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234_5678;
    es_cancel_req = 1'b1;
    tick;
    data_sram_data_ok = 1'b0;
    es_cancel_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || dut.cancel_cnt !== 2'd1)
      begin errors++; $display("FAIL rm_pre: got valid=%b cnt=%0d expected 1,1", ms_to_ws_valid, dut.cancel_cnt); end
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || dut.cancel_cnt !== 2'd0 || ms_fwd_bus !== 40'h0)
      begin errors++; $display("FAIL rm_reset: got valid=%b allowin=%b cnt=%0d fwd=%h expected 0,1,0,0",
                               ms_to_ws_valid, ms_allowin, dut.cancel_cnt, ms_fwd_bus); end
    tick;
    resetn = 1'b1;
    ws_allowin = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load_stall;
    test_backpressure;
    test_flush_drop;
    test_double_cancel;
    test_flush_hit;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
